// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment lookup for the 8-digit
// seven-segment scanner. Segment bytes are {dp,g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns for hex characters 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Full segment byte for one character; dp=1 lights the decimal point.
    function automatic logic [7:0] seg_of(input logic [3:0] nibble, input logic dp);
        return {~dp, HEX_SEG[nibble]};
    endfunction

endpackage

// File: rtl/seg7_scan_display_hex_decode.sv
// Combinational nibble + decimal point -> active-low segment byte.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg_n
);

    assign seg_n = seg_of(nibble, dp);

endmodule

// File: rtl/seg7_scan_display.sv
// Eight-digit common-anode hex scanner. Latches a 32-bit value on
// digit_valid and time-multiplexes it one digit per DIV_CNT clocks, with a
// one-cycle ghost blank at every digit switch. All outputs are registered.
// Optional build macro: SEG7_LEAD_ZERO_BLANK_EN suppresses leading zero
// digits (position 0 is always shown).
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int DIV_CNT = 50000,
    parameter int DIV_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] digit,
    input  logic        digit_valid,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an_n,
    output logic [7:0]  seg_n,
    output logic        scan_tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_CNT - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic [31:0]      shadow;
    logic             div_wrap;
    logic             switch_cycle;
    logic             pos_blank;
    logic [3:0]       cur_nibble;
    logic [7:0]       cur_seg_n;

    assign div_wrap     = (div_cnt == DIV_LAST);
    assign switch_cycle = (div_cnt == '0);

    // Divider, scan index and the tick that marks each index advance.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            idx       <= '0;
            scan_tick <= 1'b0;
        end else begin
            scan_tick <= div_wrap;
            if (div_wrap) begin
                div_cnt <= '0;
                idx     <= idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Shadow copy of the displayed value; every strobe is taken.
    // NOTE: the shadow is a plain 32-bit register, not a memory, so it is reset
    // to give a defined "00000000" display straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (digit_valid) begin
            shadow <= digit;
        end
    end

`ifdef SEG7_LEAD_ZERO_BLANK_EN
    logic [7:0] blank_mask;

    // Position i (i>0) is a leading zero when it and everything above it is 0.
    function automatic logic [7:0] lead_mask(input logic [31:0] v);
        logic [7:0] m;
        m = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            m[i] = ((v >> (4 * i)) == 32'd0);
        end
        return m;
    endfunction

    // Blank mask is captured alongside the shadow so both change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_mask <= '0;
        end else if (digit_valid) begin
            blank_mask <= lead_mask(digit);
        end
    end

    assign pos_blank = blank_mask[idx];
`else
    assign pos_blank = 1'b0;
`endif

    assign cur_nibble = shadow[{idx, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .nibble (cur_nibble),
        .dp     (dp_mask[idx]),
        .seg_n  (cur_seg_n)
    );

    // Output register: blank on the switch cycle (and for suppressed
    // positions), otherwise drive the selected anode and its character.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n  <= 8'hFF;
            seg_n <= SEG_BLANK;
        end else if (switch_cycle || pos_blank) begin
            an_n  <= 8'hFF;
            seg_n <= SEG_BLANK;
        end else begin
            an_n  <= ~(8'd1 << idx);
            seg_n <= cur_seg_n;
        end
    end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Downstream consumer of the single-cycle CPU top's 32-bit `digit` result bus.
- Latches the value on an update strobe and time-multiplexes it as 8 hex characters onto an 8-digit common-anode seven-segment display.
- Sits between the CPU top and the board pins.
- Registered outputs; ghost-blanking on every digit switch.

Parameters:
- DIV_CNT, 50000, clk cycles each digit stays selected (>=2).
- DIV_W, 16, width of the divider counter; must satisfy 2^DIV_W >= DIV_CNT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- digit  in  32  value to display; nibble i shown on display position i (position 0 = rightmost).
- digit_valid  in  1  one-cycle-or-longer strobe; digit is latched on every rising edge where high.
- dp_mask  in  8  bit i=1 lights the decimal point of position i; sampled live, not latched.
- an_n  out  8  anode enables, active-low, one-hot-low when driving.
- seg_n  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- scan_tick  out  1  one-cycle pulse when the scan index advances.

Behaviour:
- Reset (async, rst_n=0):
  - shadow=0, div_cnt=0, idx=0, scan_tick=0.
  - an_n=8'hFF, seg_n=8'hFF.
  - Leading-zero blank mask is 0 when LEAD_ZERO_BLANK_EN is defined.
  - Release is synchronous to the next rising edge.
- Divider:
  - div_cnt counts 0..DIV_CNT-1 and wraps to 0.
  - scan_tick=1 (registered) in the cycle after div_cnt==DIV_CNT-1.
  - idx increments modulo 8 on that same edge; 7 wraps to 0.
- Output register, updated each cycle from current idx/shadow (1-cycle latency):
  - If div_cnt==0 (switch cycle): an_n=8'hFF, seg_n=8'hFF. This is the ghost-blank cycle, so each digit shows DIV_CNT-1 lit cycles.
  - Otherwise: an_n=~(8'b1<<idx), seg_n[6:0]=HEX(shadow[4*idx+:4]), seg_n[7]=~dp_mask[idx].
- HEX table, active-low, dp off, 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Update:
  - digit_valid=1 at an edge sets shadow<=digit.
  - The new value is visible on seg_n at the next edge (2 edges from strobe) if not a switch cycle.
- digit_valid held high: shadow tracks digit every cycle.
- digit_valid coincident with the switch cycle: shadow updates normally; the blank cycle still occurs.
- Reset mid-scan: outputs go FF immediately (async); scanning restarts at idx 0.
- No handshake back-pressure: strobes are never dropped.

Optional Feature:
- Macro: SEG7_LEAD_ZERO_BLANK_EN.
- Defined:
  - A registered 8-bit blank mask is computed when shadow loads.
  - Position i is blanked if i > index of the highest nonzero nibble; position 0 is never blanked (value 0 shows "0" only at position 0).
  - A blanked position drives an_n=8'hFF for its whole slot. dp_mask is ignored for a blanked position.
- Undefined: all 8 positions always driven; no mask register.

Decomposition:
- Package seg7_pkg:
  - NUM_DIGITS=8, SEG_BLANK=8'hFF.
  - HEX-to-segment constant table (16x7).
  - A function seg_of(nibble,dp).
- One natural sub-module, seg7_hex_decode: combinational nibble+dp -> seg_n byte. It is instantiated once on the idx-selected nibble.
- Divider, index, shadow, optional blank mask and output register stay in the top.

Test Plan:
- Bench DIV_CNT=4.
- Reset: rst_n=0 for 3 cycles mid-operation -> an_n=FF, seg_n=FF asynchronously. After release the first lit cycle shows an_n=FE, seg_n=C0.
- Load: digit=32'h02328020, digit_valid 1 cycle -> over one 32-cycle frame:
  - pos0..7 seg_n = C0,A4,C0,80,A4,B0,A4,C0 with an_n FE,FD,FB,F7,EF,DF,BF,7F.
  - Exactly one FF/FF blank cycle per slot.
- Timing: scan_tick pulses every 4 cycles. idx 7 wraps to idx 0, so an_n returns to FE after 7F.
- Decimal point: dp_mask=8'h01 with digit=32'h00000001 -> pos0 seg_n=79; the other positions keep bit7=1.
- Simultaneous: digit_valid asserted on a switch cycle with digit=32'hFFFFFFFF -> that cycle blank. The next lit cycle shows 8E at the current position.
- SEG7_LEAD_ZERO_BLANK_EN defined:
  - digit=32'h0000001A -> only pos0 (88) and pos1 (F9) lit; positions 2..7 an_n=FF.
  - digit=0 -> only pos0 shows C0.
